// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the slow-tick scheduler.
// State encoding plus the default and minimum period values.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_DIV = 100000000;
  localparam int unsigned MIN_DIV     = 2;

endpackage

// File: rtl/div_phase_counter.sv
// Phase counter for the slow time base: wrap detect, tick
// register and the registered 50%-duty slow_clk compare.
module div_phase_counter #(
  parameter int CNT_W = 28
) (
  input  logic             clk100Mhz,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic             tick,
  output logic             slow_clk,
  output logic             at_end
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_X = (CNT_W+1)'(1);

  logic [CNT_W-1:0] phase;
  logic [CNT_W:0]   half;

  // ceil(div/2), one bit wider so div near full scale cannot overflow
  assign half   = ({1'b0, div} + ONE_X) >> 1;
  assign at_end = (phase == div - ONE);

  // Advance phase when enabled; hold everything but tick when frozen
  always_ff @(posedge clk100Mhz or posedge reset) begin
    if (reset) begin
      phase    <= '0;
      tick     <= 1'b0;
      slow_clk <= 1'b0;
    end else if (clr) begin
      phase    <= '0;
      tick     <= 1'b0;
      slow_clk <= 1'b0;
    end else if (en) begin
      phase    <= at_end ? '0 : phase + ONE;
      tick     <= at_end;
      slow_clk <= ({1'b0, phase} < half);
    end else begin
      tick     <= 1'b0;
    end
  end

endmodule

// File: rtl/tick_sched_ctrl.sv
// Start/pause/stop sequencer for the slow tick divider.
// Owns the period register, one-shot count and handshake outputs.
module tick_sched_ctrl #(
  parameter int          CNT_W       = 28,
  parameter int          NUM_W       = 16,
  parameter int unsigned DEFAULT_DIV = tick_sched_pkg::DEFAULT_DIV,
  parameter int unsigned MIN_DIV     = tick_sched_pkg::MIN_DIV
) (
  input  logic             clk100Mhz,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             oneshot,
  input  logic [NUM_W-1:0] num_ticks,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic             tick,
  output logic             slow_clk,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] ticks_left
);

  import tick_sched_pkg::*;

  localparam logic [CNT_W-1:0] DEF_V = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_DIV);
  localparam logic [NUM_W-1:0] ONE_N = NUM_W'(1);

  state_t           state;
  logic             mode_os;
  logic [CNT_W-1:0] div_reg;
  logic             at_end;
  logic             final_tick;
  logic             hold;
  logic             en;
  logic             clr;
  logic             wrap;

  // The last one-shot tick overrides a coincident pause
  assign final_tick = (state == RUN) && mode_os &&
                      (ticks_left == ONE_N) && at_end;
  assign hold = pause && !final_tick;
  assign en   = (state == RUN) && !stop && !hold;
  assign clr  = stop || (state == IDLE) || (state == DONE);
  assign wrap = en && at_end;

  div_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase (
    .clk100Mhz (clk100Mhz),
    .reset     (reset),
    .en        (en),
    .clr       (clr),
    .div       (div_reg),
    .tick      (tick),
    .slow_clk  (slow_clk),
    .at_end    (at_end)
  );

  // Controller FSM with registered busy/done/ticks_left
  always_ff @(posedge clk100Mhz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mode_os    <= 1'b0;
      div_reg    <= DEF_V;
      ticks_left <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state      <= IDLE;
        mode_os    <= 1'b0;
        ticks_left <= '0;
        busy       <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cfg_we)
              div_reg <= (cfg_div < MIN_V) ? MIN_V : cfg_div;
            if (start) begin
              mode_os <= oneshot;
              if (oneshot && (num_ticks == '0)) begin
                state      <= DONE;
                ticks_left <= '0;
              end else begin
                state      <= RUN;
                busy       <= 1'b1;
                ticks_left <= oneshot ? num_ticks : '0;
              end
            end
          end
          RUN: begin
            if (wrap && mode_os) begin
              ticks_left <= ticks_left - ONE_N;
              if (ticks_left == ONE_N) begin
                state <= DONE;
                busy  <= 1'b0;
              end
            end else if (hold) begin
              state <= PAUSED;
            end
          end
          PAUSED: begin
            if (start && !pause)
              state <= RUN;
          end
          DONE: begin
            done  <= 1'b1;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// Bench for tick_sched_ctrl: directed scenarios plus random
// traffic, checked cycle by cycle against a behavioural model.
module tb_tick_sched_ctrl;

  localparam int DEF = 24;

  logic        clk100Mhz = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [27:0] cfg_div = '0;
  logic        oneshot = 1'b0;
  logic [15:0] num_ticks = '0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop = 1'b0;
  logic        tick;
  logic        slow_clk;
  logic        busy;
  logic        done;
  logic [15:0] ticks_left;

  int total = 0;
  int bad = 0;

  // model: ms 0 idle, 1 run, 2 paused, 3 done
  int ms, mdiv, mpos, mleft;
  bit mos, e_tick, e_slow, e_busy, e_done;

  always #5 clk100Mhz = ~clk100Mhz;

  tick_sched_ctrl #(
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk100Mhz  (clk100Mhz),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_div    (cfg_div),
    .oneshot    (oneshot),
    .num_ticks  (num_ticks),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .tick       (tick),
    .slow_clk   (slow_clk),
    .busy       (busy),
    .done       (done),
    .ticks_left (ticks_left)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = 0; mdiv = DEF; mpos = 0; mleft = 0;
    mos = 0; e_tick = 0; e_slow = 0;
    e_busy = 0; e_done = 0;
  endtask

  // one clock edge of the spec's rules, in period-position terms
  task automatic model_step();
    bit last;
    e_done = 0;
    if (stop) begin
      ms = 0; mpos = 0; mleft = 0;
      e_slow = 0; e_tick = 0; mos = 0;
    end else begin
      case (ms)
        0: begin
          e_tick = 0; e_slow = 0; mpos = 0;
          if (cfg_we) mdiv = (cfg_div < 2) ? 2 : int'(cfg_div);
          if (start) begin
            mos = oneshot;
            if (oneshot && num_ticks == 0) begin
              ms = 3; mleft = 0;
            end else begin
              ms = 1;
              mleft = oneshot ? int'(num_ticks) : 0;
            end
          end
        end
        1: begin
          last = mos && mleft == 1 && mpos == mdiv - 1;
          if (pause && !last) begin
            ms = 2; e_tick = 0;
          end else begin
            e_slow = mpos < (mdiv + 1) / 2;
            mpos = (mpos + 1) % mdiv;
            e_tick = (mpos == 0);
            if (e_tick && mos) begin
              mleft--;
              if (mleft == 0) ms = 3;
            end
          end
        end
        2: begin
          e_tick = 0;
          if (start && !pause) ms = 1;
        end
        default: begin
          e_done = 1; e_tick = 0; e_slow = 0;
          ms = 0; mpos = 0;
        end
      endcase
    end
    e_busy = (ms == 1) || (ms == 2);
  endtask

  task automatic check_all();
    chk("tick", tick, e_tick);
    chk("slow_clk", slow_clk, e_slow);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("ticks_left", ticks_left, mleft);
  endtask

  task automatic cyc();
    @(posedge clk100Mhz);
    model_step();
    @(negedge clk100Mhz);
    check_all();
  endtask

  task automatic pulse_start(input bit os, input int n);
    oneshot = os; num_ticks = 16'(n); start = 1;
    cyc();
    start = 0;
  endtask

  task automatic write_div(input int d);
    cfg_we = 1; cfg_div = 28'(d);
    cyc();
    cfg_we = 0;
  endtask

  task automatic do_stop();
    stop = 1;
    cyc();
    stop = 0;
  endtask

  initial begin
    int lat, cnt;
    logic [31:0] mask, pat;
    model_reset();
    repeat (2) @(negedge clk100Mhz);
    check_all();
    reset = 0;

    // 1: default period after reset
    pulse_start(0, 0);
    lat = 0; cnt = 0;
    for (int i = 1; i <= 2 * DEF; i++) begin
      cyc();
      if (tick && lat == 0) lat = i;
      cnt += int'(slow_clk);
    end
    chk("t1_first_tick", lat, DEF);
    chk("t1_slow_high", cnt, 2 * ((DEF + 1) / 2));
    do_stop();

    // 2: one-shot of 3 ticks at div 4
    write_div(4);
    pulse_start(1, 3);
    mask = 0; lat = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (tick) mask[i] = 1'b1;
      if (done) lat = i;
    end
    chk("t2_tick_mask", mask, 32'h1110);
    chk("t2_done_at", lat, 13);
    chk("t2_busy_end", busy, 0);

    // 3: div 5 duty pattern, write during RUN ignored
    write_div(5);
    pulse_start(0, 0);
    pat = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      pat = (pat << 1) | 32'(slow_clk);
    end
    chk("t3_pattern", pat, 32'h39C);
    write_div(9);
    cnt = 0;
    repeat (20) begin
      cyc();
      cnt += int'(tick);
    end
    chk("t3_ticks_20", cnt, 4);
    do_stop();

    // 4: clamp to 2, then zero-length one-shot
    write_div(1);
    pulse_start(0, 0);
    cnt = 0;
    repeat (10) begin
      cyc();
      cnt += int'(tick);
    end
    chk("t4_ticks_10", cnt, 5);
    do_stop();
    pulse_start(1, 0);
    cyc();
    chk("t4_done", done, 1);
    chk("t4_no_tick", tick, 0);

    // 5: pause at phase 3 of div 8, resume, then stop+pause+start
    write_div(8);
    pulse_start(1, 5);
    repeat (3) cyc();
    pause = 1;
    cyc();
    pause = 0;
    cnt = 0;
    repeat (20) begin
      cyc();
      cnt += int'(tick);
    end
    chk("t5_frozen_ticks", cnt, 0);
    chk("t5_left_frozen", ticks_left, 5);
    start = 1;
    cyc();
    start = 0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (tick && lat == 0) lat = i;
    end
    chk("t5_resume_tick", lat, 5);
    stop = 1; pause = 1; start = 1;
    cyc();
    stop = 0; pause = 0; start = 0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_left", ticks_left, 0);
    cyc();
    chk("t5_abort_done", done, 0);

    // 6: asynchronous reset mid-RUN
    pulse_start(1, 7);
    repeat (11) cyc();
    @(posedge clk100Mhz);
    #3 reset = 1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_left", ticks_left, 0);
    chk("t6_slow", slow_clk, 0);
    chk("t6_tick", tick, 0);
    model_reset();
    @(negedge clk100Mhz);
    check_all();
    reset = 0;
    repeat (30) cyc();
    pulse_start(0, 0);
    lat = 0;
    for (int i = 1; i <= DEF + 2; i++) begin
      cyc();
      if (tick && lat == 0) lat = i;
    end
    chk("t6_default_div", lat, DEF);
    do_stop();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_div   = 28'($urandom_range(0, 9));
      oneshot   = 1'($urandom_range(0, 1));
      num_ticks = 16'($urandom_range(0, 4));
      start     = ($urandom_range(0, 7) == 0);
      pause     = ($urandom_range(0, 15) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
